// File: rtl/pwm_multichannel.sv
// N-channel PWM generator: shared prescaler and period counter, per-channel duty
// shadow/active registers committed at the period wrap, registered outputs.

module pwm_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             wrap,
  input  logic [CNT_W-1:0] cnt,
  input  logic             en_out,
  input  logic             en_pwm,
  output logic             out
);
  logic [CNT_W-1:0] shadow, active;
  logic             pwm_bit;

  // All-ones duty is forced high so full duty never drops out at cnt==max.
  assign pwm_bit = (&active) | (cnt < active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      out    <= 1'b0;
    end else begin
      if (wr_hit) shadow <= wr_val;
      // A write landing on the wrap cycle is forwarded straight into the new period.
      if (wrap)   active <= wr_hit ? wr_val : shadow;
      out <= en_out & (~en_pwm | pwm_bit);
    end
  end
endmodule

module pwm_multichannel #(
  parameter int NUM_CH     = 16,
  parameter int CNT_W      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     en_out,
  input  logic [NUM_CH-1:0]     en_pwm,
  input  logic                  duty_wr_en,
  input  logic [CH_W-1:0]       duty_wr_ch,
  input  logic [CNT_W-1:0]      duty_wr_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [NUM_CH-1:0]     out,
  output logic                  period_start
);
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [CNT_W-1:0]      cnt;
  logic                  tick, wrap;
  logic [NUM_CH-1:0]     wr_hit;

  // >= rather than == so a lowered prescale recovers on the next cycle.
  assign tick = (pre_cnt >= prescale);
  assign wrap = tick & (&cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre_cnt      <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
      if (tick) cnt <= cnt + CNT_W'(1);
      period_start <= wrap;
    end
  end

  // Out-of-range channel indices match no lane, so such writes fall away.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      wr_hit[i] = duty_wr_en && (duty_wr_ch == CH_W'(i));
  end

  pwm_ch #(.CNT_W(CNT_W)) u_ch [NUM_CH-1:0] (
    .clk    (clk),
    .rst    (rst),
    .wr_hit (wr_hit),
    .wr_val (duty_wr_val),
    .wrap   (wrap),
    .cnt    (cnt),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .out    (out)
  );
endmodule
